// File: rtl/multi_adc_extremum_pkg.sv
// Shared types and constants for the multi-channel A/D extremum block.
package multi_adc_extremum_pkg;

  // Sequencer states, fixed 2-bit encoding
  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_WAIT  = 2'd1,
    S_PRES  = 2'd2,
    S_REL   = 2'd3
  } state_t;

  // Extremum select
  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

endpackage

// File: rtl/multi_adc_extremum_if.sv
// Converter/consumer bus of the extremum block. The block is the slave side.
interface multi_adc_extremum_if #(
  parameter int N = 3,
  parameter int W = 8
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   eoc;
  logic [N*W-1:0] x;
  logic [N-1:0]   ch_mask;
  logic           mode;
  logic           rfd;
  logic           soc;
  logic           dav_;
  logic [W-1:0]   result;
  logic [IW-1:0]  idx;

  modport slave  (input  eoc, x, ch_mask, mode, rfd,
                  output soc, dav_, result, idx);
  modport master (output eoc, x, ch_mask, mode, rfd,
                  input  soc, dav_, result, idx);
endinterface

// File: rtl/multi_adc_extremum_extremum_n.sv
// Combinational min/max over the enabled channels. Linear chain of
// borrow-based compare-and-select stages; a strict compare keeps the
// earlier (lower) index on ties, and disabled channels are skipped.
module extremum_n
  import multi_adc_extremum_pkg::*;
#(
  parameter int N  = 3,
  parameter int W  = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N*W-1:0] x,
  input  logic [N-1:0]   mask,
  input  logic           mode,
  output logic [W-1:0]   value,
  output logic [IW-1:0]  idx
);

  // Borrow out of a - b over W bits: set exactly when a < b (unsigned)
  function automatic logic borrow_out(input logic [W-1:0] a, input logic [W-1:0] b);
    logic br;
    br = 1'b0;
    for (int j = 0; j < W; j++)
      br = (~a[j] & b[j]) | (~(a[j] ^ b[j]) & br);
    return br;
  endfunction

  logic [W-1:0]  w_best;
  logic [IW-1:0] w_idx;
  logic          w_have;
  logic [W-1:0]  w_cand;
  logic          w_better;

  // Walk channels in index order, replacing the running best only on a strict win
  always_comb begin
    w_best   = '0;
    w_idx    = '0;
    w_have   = 1'b0;
    w_cand   = '0;
    w_better = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_cand   = x[i*W +: W];
      w_better = (mode == MODE_MAX) ? borrow_out(w_best, w_cand)
                                    : borrow_out(w_cand, w_best);
      if (mask[i] && (!w_have || w_better)) begin
        w_best = w_cand;
        w_idx  = IW'(i);
        w_have = 1'b1;
      end
    end
  end

  assign value = w_best;
  assign idx   = w_idx;

endmodule

// File: rtl/multi_adc_extremum.sv
// Start/wait/present/release sequencer: fires the converters, waits for all
// enabled channels, latches the min or max sample and hands it to the
// consumer with an active-low data-available handshake.
module multi_adc_extremum
  import multi_adc_extremum_pkg::*;
#(
  parameter int N = 3,
  parameter int W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  multi_adc_extremum_if.slave    bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t        r_state, w_next;
  logic          r_soc, r_dav_n;
  logic [N-1:0]  r_mask;
  logic          r_mode;
  logic [W-1:0]  r_result;
  logic [IW-1:0] r_idx;

  logic [N-1:0]  w_mask_eff;
  logic [W-1:0]  w_value;
  logic [IW-1:0] w_idx;
  logic          w_load;

  // An empty mask means "use every channel"
  assign w_mask_eff = (bus.ch_mask == '0) ? '1 : bus.ch_mask;

  extremum_n #(.N(N), .W(W)) u_ext (
    .x     (bus.x),
    .mask  (r_mask),
    .mode  (r_mode),
    .value (w_value),
    .idx   (w_idx)
  );

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_START: if ((bus.eoc & w_mask_eff) == '0) w_next = S_WAIT;
      S_WAIT:  if (&(bus.eoc | ~r_mask))         w_next = S_PRES;
      S_PRES:  if (bus.rfd)                       w_next = S_REL;
      S_REL:   if (!bus.rfd)                      w_next = S_START;
      default:                                    w_next = S_START;
    endcase
  end

  assign w_load = (r_state == S_WAIT) && (w_next == S_PRES);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_START;
    else       r_state <= w_next;
  end

  // Registered handshake outputs follow the state being entered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_soc   <= 1'b0;
      r_dav_n <= 1'b1;
    end else begin
      r_soc   <= (w_next == S_START);
      r_dav_n <= (w_next != S_PRES);
    end
  end

  // Mask/mode track the inputs only while starting; frozen afterwards
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mask <= '1;
      r_mode <= MODE_MIN;
    end else if (r_state == S_START) begin
      r_mask <= w_mask_eff;
      r_mode <= bus.mode;
    end
  end

  // Result capture only when all enabled conversions have completed
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_idx    <= '0;
    end else if (w_load) begin
      r_result <= w_value;
      r_idx    <= w_idx;
    end
  end

  assign bus.soc    = r_soc;
  assign bus.dav_   = r_dav_n;
  assign bus.result = r_result;
  assign bus.idx    = r_idx;

endmodule

// File: tb/tb_multi_adc_extremum.sv
// Directed bench for multi_adc_extremum (N=3/W=8 and N=5/W=12 instances).
module tb_multi_adc_extremum;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clock = ~clock;

  multi_adc_extremum_if #(.N(3), .W(8))  b1();
  multi_adc_extremum_if #(.N(5), .W(12)) b2();

  multi_adc_extremum #(.N(3), .W(8))  u1 (.clock(clock), .reset(reset), .bus(b1));
  multi_adc_extremum #(.N(5), .W(12)) u2 (.clock(clock), .reset(reset), .bus(b2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // One conversion on the N=3 instance, ending one edge into S_PRES.
  // Mask/mode/x are scrambled while waiting to show they are ignored there.
  task automatic conv(input string tag, input logic [2:0] m, input logic md,
                      input logic [23:0] xv, input logic [7:0] er, input logic [1:0] ei);
    logic [2:0] eff;
    eff = (m == 3'b000) ? 3'b111 : m;
    b1.ch_mask = m; b1.mode = md; b1.x = xv; b1.eoc = eff;
    tick();
    chk({tag, ".start_soc"}, b1.soc, 1'b1);
    b1.eoc = 3'b000;
    tick();
    b1.ch_mask = ~m; b1.mode = ~md; b1.x = ~xv;
    tick();
    chk({tag, ".wait_soc"}, b1.soc, 1'b0);
    chk({tag, ".wait_dav"}, b1.dav_, 1'b1);
    b1.x = xv; b1.eoc = eff;
    tick();
    chk({tag, ".pres_dav"}, b1.dav_, 1'b0);
    chk({tag, ".result"}, b1.result, er);
    chk({tag, ".idx"}, b1.idx, ei);
  endtask

  initial begin
    b1.eoc = '0; b1.x = '0; b1.ch_mask = 3'b111; b1.mode = 1'b0; b1.rfd = 1'b0;
    b2.eoc = '0; b2.x = '0; b2.ch_mask = 5'b11111; b2.mode = 1'b0; b2.rfd = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst.soc", b1.soc, 1'b0);
    chk("rst.dav", b1.dav_, 1'b1);
    chk("rst.result", b1.result, 8'd0);
    chk("rst.idx", b1.idx, 2'd0);
    reset = 1'b0;

    // Minimum with a normal handshake
    conv("min", 3'b111, 1'b0, {8'd200, 8'd17, 8'd40}, 8'd17, 2'd1);
    tick();
    chk("min.hold_dav", b1.dav_, 1'b0);
    b1.rfd = 1'b1;
    tick();
    chk("min.rel_dav", b1.dav_, 1'b1);
    chk("min.rel_result", b1.result, 8'd17);
    b1.rfd = 1'b0;
    tick();
    chk("min.restart_soc", b1.soc, 1'b1);

    // Maximum, tie goes to the lowest index
    conv("maxtie", 3'b111, 1'b1, {8'd200, 8'd90, 8'd200}, 8'd200, 2'd0);
    b1.rfd = 1'b1; tick(); b1.rfd = 1'b0; tick();

    // Masked channel 1 never converts and must not win
    conv("mask", 3'b101, 1'b0, {8'd60, 8'd3, 8'd50}, 8'd50, 2'd0);
    b1.rfd = 1'b1; tick(); b1.rfd = 1'b0; tick();

    // Empty mask means all channels; rfd already high on S_PRES entry
    b1.rfd = 1'b1;
    conv("empty", 3'b000, 1'b0, {8'd7, 8'd8, 8'd9}, 8'd7, 2'd2);
    tick();
    chk("empty.rel_dav", b1.dav_, 1'b1);
    chk("empty.rel_soc", b1.soc, 1'b0);
    tick();
    chk("empty.hold_soc", b1.soc, 1'b0);
    b1.rfd = 1'b0;
    tick();
    chk("empty.restart_soc", b1.soc, 1'b1);

    // Asynchronous reset while waiting
    b1.ch_mask = 3'b111; b1.mode = 1'b0; b1.eoc = 3'b111;
    tick();
    b1.eoc = 3'b000;
    tick();
    #2 reset = 1'b1;
    #1;
    chk("arst.soc", b1.soc, 1'b0);
    chk("arst.dav", b1.dav_, 1'b1);
    chk("arst.result", b1.result, 8'd0);
    chk("arst.idx", b1.idx, 2'd0);
    @(negedge clock);
    reset = 1'b0;
    b1.eoc = 3'b111;
    tick();
    chk("arst.restart_soc", b1.soc, 1'b1);

    // Wide instance: left reset in S_WAIT since its eoc stays low
    b2.x = {12'd0, 12'd1, 12'd4095, 12'd0, 12'd4095};
    b2.eoc = 5'b11111;
    tick();
    chk("w12.min_dav", b2.dav_, 1'b0);
    chk("w12.min_result", b2.result, 12'd0);
    chk("w12.min_idx", b2.idx, 3'd1);
    b2.rfd = 1'b1; tick(); b2.rfd = 1'b0; tick();
    b2.mode = 1'b1;
    tick();
    b2.eoc = 5'b00000;
    tick();
    b2.eoc = 5'b11111;
    tick();
    chk("w12.max_result", b2.result, 12'd4095);
    chk("w12.max_idx", b2.idx, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
